branch_resolve_unit: RTL and testbench
======================================

Name: branch_resolve_unit

Overview:
- Sits between fetch (predictor output) and execute (branch outcome).
- Records every fetched branch's prediction in an in-order tracking FIFO and compares it with the real outcome from execute.
- On a misprediction it raises flush and redirect and drops wrong-path entries.
- Produces the registered taken/not-taken update stream that trains the 2-bit saturating-counter predictor.

Parameters:
- XLEN, 32, address/data width.
- DEPTH, 4, number of tracking FIFO entries; power of 2, minimum 2.
- PTR_W, $clog2(DEPTH), pointer width; count width is PTR_W+1.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-high.
- fetch_br_valid  in  1  branch fetched this cycle; push request.
- fetch_pc  in  XLEN  PC of the fetched branch.
- fetch_pred_taken  in  1  predictor output for this branch.
- fetch_pred_target  in  XLEN  target fetch used when predicted taken.
- fetch_stall  out  1  FIFO full; combinational (count==DEPTH).
- ex_br_valid  in  1  branch resolved in execute this cycle; pop request; always the oldest outstanding branch.
- ex_taken  in  1  actual direction.
- ex_target  in  XLEN  actual target.
- flush  out  1  registered one-cycle pulse on mispredict.
- redirect_pc  out  XLEN  correct next PC; valid while flush=1.
- upd_valid  out  1  registered predictor update strobe.
- upd_taken  out  1  drives predictor branch_taken.
- upd_pc  out  XLEN  PC of the resolved branch.
- fifo_empty  out  1  count==0.
- underflow_err  out  1  sticky; set by ex_br_valid while empty.

Behaviour:
- Reset (async): pointers=0; count=0; flush=0; redirect_pc=0; upd_valid=0; upd_taken=0; upd_pc=0; underflow_err=0. A reset mid-operation discards all entries immediately.
- Entry fields: {pc, pred_taken, pred_target}.
- Push: fetch_br_valid && !full && !mispredict_now. Writes the entry at the write pointer. Pointers wrap modulo DEPTH.
- Pop: ex_br_valid && !empty. Compares against the head entry combinationally:
  - mispredict_now = (pred_taken != ex_taken) || (ex_taken && pred_target != ex_target).
- Outputs, 1 cycle after pop:
  - upd_valid=1, upd_taken=ex_taken, upd_pc=head.pc.
  - flush=mispredict_now.
  - redirect_pc = ex_taken ? ex_target : head.pc+4, with XLEN wrap.
  - upd_valid is issued for every pop, whether the prediction was right or wrong.
- Mispredict edge: pointers and count are cleared. Any simultaneous push is dropped as wrong-path.
- Flush cycle: pushes are also ignored, because fetch is being redirected.
- Pop with no mispredict: rd_ptr++, count--.
- Simultaneous push and pop: count is unchanged and both pointers advance.
- Full: fetch_stall=1 and the push is dropped, even if a pop occurs the same cycle. This avoids a comb path from ex to fetch.
- Empty with ex_br_valid: no pop, no update, underflow_err set (cleared only by reset).
- All outputs except fetch_stall and fifo_empty are registered.

Optional Feature:
- Macro: BRU_PERF_CNT_EN.
- When defined:
  - Adds outputs perf_branches[31:0] (count of pops) and perf_mispredicts[31:0] (count of flushes).
  - Both reset to 0, increment on the same edge as upd_valid/flush rise, and saturate at 32'hFFFF_FFFF.
- When undefined: the ports and counters are absent. Core behaviour is identical.

Decomposition:
- Shared package bru_pkg holds:
  - the br_entry_t struct {pc, pred_taken, pred_target};
  - the default XLEN/DEPTH constants;
  - the PC_INCR=4 constant.
- One sub-module: bru_track_fifo. It is a synchronous FIFO with a clear input and full/empty/count outputs. The compare/redirect logic stays in the top level.

Test Plan:
- Reset, then push pc=0x100 pred_taken=0; resolve ex_taken=0.
  - Next cycle: upd_valid=1, upd_taken=0, upd_pc=0x100, flush=0, fifo_empty=1.
- Push pc=0x200 pred_taken=0; resolve ex_taken=1 ex_target=0x280.
  - Next cycle: flush=1, redirect_pc=0x280, upd_taken=1.
- Push pc=0x300 pred_taken=1 target=0x340, plus 2 younger branches; resolve ex_taken=0.
  - Result: flush=1, redirect_pc=0x304, FIFO empty; a push on the mispredict cycle is dropped.
- Taken-target mismatch: pred_taken=1 target=0x400, ex_taken=1 ex_target=0x480.
  - Result: flush=1, redirect_pc=0x480.
- Full and wrap:
  - Push 4 branches: fetch_stall=1 and a 5th push is dropped.
  - Pop+push each cycle for 8 cycles: upd_pc order matches push order across the wrap.
- ex_br_valid while empty:
  - Result: underflow_err=1 persists, upd_valid=0.
  - Assert reset mid-stream with 3 entries: all outputs return to 0 asynchronously.

Source files
------------

// File: rtl/bru_pkg.sv
// Shared types and constants for the branch resolve unit.
package bru_pkg;

    localparam int BRU_XLEN  = 32;
    localparam int BRU_DEPTH = 4;
    localparam int unsigned PC_INCR = 4;

    // One tracked branch: where it was fetched and what the predictor said.
    typedef struct packed {
        logic [BRU_XLEN-1:0] pc;
        logic                pred_taken;
        logic [BRU_XLEN-1:0] pred_target;
    } br_entry_t;

endpackage

// File: rtl/bru_track_fifo.sv
// In-order tracking FIFO for outstanding branches; clear drops every entry at once.
module bru_track_fifo
    import bru_pkg::*;
#(
    parameter int DEPTH = BRU_DEPTH,
    parameter int PTR_W = $clog2(DEPTH)
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           clear,
    input  logic           push,
    input  logic           pop,
    input  br_entry_t      wr_data,
    output br_entry_t      rd_data,
    output logic           full,
    output logic           empty,
    output logic [PTR_W:0] count
);

    localparam logic [PTR_W:0]   FULL_CNT = (PTR_W+1)'(DEPTH);
    localparam logic [PTR_W:0]   CNT_ONE  = (PTR_W+1)'(1);
    localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);

    br_entry_t        mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;

    assign full    = (count == FULL_CNT);
    assign empty   = (count == '0);
    assign rd_data = mem[rd_ptr];

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_ONE;
            if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
            if (push && !pop)      count <= count + CNT_ONE;
            else if (pop && !push) count <= count - CNT_ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (push && !clear) mem[wr_ptr] <= wr_data;
    end

endmodule

// File: rtl/branch_resolve_unit.sv
// Tracks fetched branch predictions, resolves them against execute, and raises flush/redirect.
// Optional BRU_PERF_CNT_EN adds saturating pop and mispredict counters.
module branch_resolve_unit
    import bru_pkg::*;
#(
    parameter int XLEN  = BRU_XLEN,
    parameter int DEPTH = BRU_DEPTH,
    parameter int PTR_W = $clog2(DEPTH)
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            fetch_br_valid,
    input  logic [XLEN-1:0] fetch_pc,
    input  logic            fetch_pred_taken,
    input  logic [XLEN-1:0] fetch_pred_target,
    output logic            fetch_stall,
    input  logic            ex_br_valid,
    input  logic            ex_taken,
    input  logic [XLEN-1:0] ex_target,
    output logic            flush,
    output logic [XLEN-1:0] redirect_pc,
    output logic            upd_valid,
    output logic            upd_taken,
    output logic [XLEN-1:0] upd_pc,
    output logic            fifo_empty,
    output logic            underflow_err
`ifdef BRU_PERF_CNT_EN
    ,
    output logic [31:0]     perf_branches,
    output logic [31:0]     perf_mispredicts
`endif
);

    localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(DEPTH);

    br_entry_t      wr_entry;
    br_entry_t      head;
    logic           full;
    logic           empty;
    logic [PTR_W:0] count;
    logic           push;
    logic           pop;
    logic           mispredict_now;

    // Valid-only handshakes: fetch pushes when fetch_br_valid && !fetch_stall and it is not a
    // mispredict or flush cycle; execute pops when ex_br_valid and an entry is outstanding.
    // Execute always resolves the oldest outstanding branch.
    assign pop            = ex_br_valid && !empty;
    assign mispredict_now = pop && ((head.pred_taken != ex_taken) ||
                                    (ex_taken && (head.pred_target != ex_target)));
    assign push           = fetch_br_valid && !full && !mispredict_now && !flush;

    assign wr_entry.pc          = fetch_pc;
    assign wr_entry.pred_taken  = fetch_pred_taken;
    assign wr_entry.pred_target = fetch_pred_target;

    assign fetch_stall = (count == FULL_CNT);
    assign fifo_empty  = (count == '0);

    bru_track_fifo #(
        .DEPTH (DEPTH),
        .PTR_W (PTR_W)
    ) u_track_fifo (
        .clk     (clk),
        .reset   (reset),
        .clear   (mispredict_now),
        .push    (push),
        .pop     (pop),
        .wr_data (wr_entry),
        .rd_data (head),
        .full    (full),
        .empty   (empty),
        .count   (count)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            flush         <= 1'b0;
            redirect_pc   <= '0;
            upd_valid     <= 1'b0;
            upd_taken     <= 1'b0;
            upd_pc        <= '0;
            underflow_err <= 1'b0;
        end else begin
            upd_valid <= pop;
            flush     <= mispredict_now;
            if (pop) begin
                upd_taken   <= ex_taken;
                upd_pc      <= head.pc;
                redirect_pc <= ex_taken ? ex_target : head.pc + XLEN'(PC_INCR);
            end
            if (ex_br_valid && empty) underflow_err <= 1'b1;
        end
    end

`ifdef BRU_PERF_CNT_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            perf_branches    <= '0;
            perf_mispredicts <= '0;
        end else begin
            if (pop && (perf_branches != '1))               perf_branches    <= perf_branches + 32'd1;
            if (mispredict_now && (perf_mispredicts != '1)) perf_mispredicts <= perf_mispredicts + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Scoreboard bench for branch_resolve_unit: a queue-based model predicts every update/flush.
module tb_branch_resolve_unit;

    localparam int XLEN  = 32;
    localparam int DEPTH = 4;
    localparam int EW    = 2 + 2 * XLEN;

    logic            clk;
    logic            reset;
    logic            fetch_br_valid;
    logic [XLEN-1:0] fetch_pc;
    logic            fetch_pred_taken;
    logic [XLEN-1:0] fetch_pred_target;
    logic            fetch_stall;
    logic            ex_br_valid;
    logic            ex_taken;
    logic [XLEN-1:0] ex_target;
    logic            flush;
    logic [XLEN-1:0] redirect_pc;
    logic            upd_valid;
    logic            upd_taken;
    logic [XLEN-1:0] upd_pc;
    logic            fifo_empty;
    logic            underflow_err;
`ifdef BRU_PERF_CNT_EN
    logic [31:0]     perf_branches;
    logic [31:0]     perf_mispredicts;
`endif

    branch_resolve_unit #(.XLEN(XLEN), .DEPTH(DEPTH)) dut (
        .clk               (clk),
        .reset             (reset),
        .fetch_br_valid    (fetch_br_valid),
        .fetch_pc          (fetch_pc),
        .fetch_pred_taken  (fetch_pred_taken),
        .fetch_pred_target (fetch_pred_target),
        .fetch_stall       (fetch_stall),
        .ex_br_valid       (ex_br_valid),
        .ex_taken          (ex_taken),
        .ex_target         (ex_target),
        .flush             (flush),
        .redirect_pc       (redirect_pc),
        .upd_valid         (upd_valid),
        .upd_taken         (upd_taken),
        .upd_pc            (upd_pc),
        .fifo_empty        (fifo_empty),
        .underflow_err     (underflow_err)
`ifdef BRU_PERF_CNT_EN
        ,
        .perf_branches     (perf_branches),
        .perf_mispredicts  (perf_mispredicts)
`endif
    );

    // ---------------- clock / reset ----------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // ---------------- reference model ----------------
    typedef struct {
        logic [XLEN-1:0] pc;
        logic            pt;
        logic [XLEN-1:0] tgt;
    } m_entry_t;

    m_entry_t        model_q[$];
    logic [EW-1:0]   exp_q[$];      // {flush, taken, pc, redirect}
    bit              model_flush;
    bit              model_uf;
    int              m_branches;
    int              m_misp;
    int              n_checks;
    int              n_fail;

    task automatic check(input string name, input logic [XLEN-1:0] act, input logic [XLEN-1:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, req, $time);
        end
    endtask

    // ---------------- driver ----------------
    task automatic step(input logic fv, input logic [XLEN-1:0] pc, input logic pt,
                        input logic [XLEN-1:0] ptgt, input logic ev, input logic et,
                        input logic [XLEN-1:0] etgt);
        m_entry_t h;
        m_entry_t n;
        bit       do_pop;
        bit       do_push;
        bit       misp;
        @(negedge clk);
        fetch_br_valid    = fv;
        fetch_pc          = pc;
        fetch_pred_taken  = pt;
        fetch_pred_target = ptgt;
        ex_br_valid       = ev;
        ex_taken          = et;
        ex_target         = etgt;
        #1;
        check("fetch_stall", XLEN'(fetch_stall), XLEN'(model_q.size() == DEPTH));
        check("fifo_empty", XLEN'(fifo_empty), XLEN'(model_q.size() == 0));
        check("underflow_err", XLEN'(underflow_err), XLEN'(model_uf));
        do_pop = ev && (model_q.size() != 0);
        misp   = 1'b0;
        if (do_pop) begin
            h    = model_q[0];
            misp = (h.pt != et) || (et && (h.tgt != etgt));
            exp_q.push_back({misp, et, h.pc, et ? etgt : h.pc + 32'd4});
            m_branches++;
            if (misp) m_misp++;
        end
        if (ev && model_q.size() == 0) model_uf = 1'b1;
        do_push = fv && (model_q.size() != DEPTH) && !misp && !model_flush;
        if (misp) begin
            model_q.delete();
        end else begin
            if (do_pop) void'(model_q.pop_front());
            if (do_push) begin
                n.pc  = pc;
                n.pt  = pt;
                n.tgt = ptgt;
                model_q.push_back(n);
            end
        end
        model_flush = misp;
    endtask

    task automatic idle();
        step(1'b0, '0, 1'b0, '0, 1'b0, 1'b0, '0);
    endtask

    // ---------------- monitor / scoreboard ----------------
    logic [EW-1:0] mon_e;
    always @(posedge clk) begin
        #1;
        if (!reset) begin
            if (upd_valid) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_upd: got upd_pc 0x%0h expected no update", upd_pc);
                end else begin
                    mon_e = exp_q.pop_front();
                    check("upd_taken", XLEN'(upd_taken), XLEN'(mon_e[EW-2]));
                    check("upd_pc", upd_pc, mon_e[2*XLEN-1:XLEN]);
                    check("flush", XLEN'(flush), XLEN'(mon_e[EW-1]));
                    if (mon_e[EW-1]) check("redirect_pc", redirect_pc, mon_e[XLEN-1:0]);
                end
            end else begin
                check("flush_without_upd", XLEN'(flush), '0);
            end
        end
    end

    // ---------------- stimulus ----------------
    logic            r_fv;
    logic            r_pt;
    logic            r_ev;
    logic            r_et;
    logic [XLEN-1:0] r_pc;
    logic [XLEN-1:0] r_ptgt;
    logic [XLEN-1:0] r_etgt;

    task automatic check_reset_outputs();
        check("rst_flush", XLEN'(flush), '0);
        check("rst_redirect_pc", redirect_pc, '0);
        check("rst_upd_valid", XLEN'(upd_valid), '0);
        check("rst_upd_taken", XLEN'(upd_taken), '0);
        check("rst_upd_pc", upd_pc, '0);
        check("rst_underflow_err", XLEN'(underflow_err), '0);
        check("rst_fifo_empty", XLEN'(fifo_empty), 32'd1);
        check("rst_fetch_stall", XLEN'(fetch_stall), '0);
`ifdef BRU_PERF_CNT_EN
        check("rst_perf_branches", perf_branches, '0);
        check("rst_perf_mispredicts", perf_mispredicts, '0);
`endif
    endtask

    initial begin
        n_checks = 0; n_fail = 0;
        model_flush = 0; model_uf = 0; m_branches = 0; m_misp = 0;
        reset = 1'b1;
        fetch_br_valid = 0; fetch_pc = '0; fetch_pred_taken = 0; fetch_pred_target = '0;
        ex_br_valid = 0; ex_taken = 0; ex_target = '0;
        #1;
        check_reset_outputs();
        @(negedge clk);
        reset = 1'b0;

        // Correct not-taken prediction.
        step(1, 32'h100, 0, 32'h0, 0, 0, 0);
        step(0, 0, 0, 0, 1, 0, 0);
        idle();
        // Predicted not-taken, actually taken.
        step(1, 32'h200, 0, 32'h0, 0, 0, 0);
        step(0, 0, 0, 0, 1, 1, 32'h280);
        idle();
        // Predicted taken, actually not taken; younger branches and a same-cycle push are dropped.
        step(1, 32'h300, 1, 32'h340, 0, 0, 0);
        step(1, 32'h310, 0, 32'h0, 0, 0, 0);
        step(1, 32'h320, 0, 32'h0, 0, 0, 0);
        step(1, 32'h330, 0, 32'h0, 1, 0, 32'h0);
        step(1, 32'h338, 0, 32'h0, 0, 0, 0);     // flush cycle: ignored
        idle();
        // Taken with wrong target.
        step(1, 32'h400, 1, 32'h400, 0, 0, 0);
        step(0, 0, 0, 0, 1, 1, 32'h480);
        idle();
        // Fill to full, fifth push dropped, then pop+push across the pointer wrap.
        for (int i = 0; i < 5; i++) step(1, 32'h500 + 32'(i * 16), 0, 32'h0, 0, 0, 0);
        for (int i = 0; i < 8; i++) step(1, 32'h600 + 32'(i * 16), 0, 32'h0, 1, 0, 32'h0);
        for (int i = 0; i < 5; i++) step(0, 0, 0, 0, 1, 0, 32'h0);
        // Resolve while empty.
        step(0, 0, 0, 0, 1, 0, 32'h0);
        idle();
        idle();

        // Random traffic against the model.
        for (int i = 0; i < 400; i++) begin
            r_fv   = 1'($urandom_range(0, 1));
            r_pc   = $urandom & 32'hFFFF_FFFC;
            r_pt   = 1'($urandom_range(0, 1));
            r_ptgt = {28'h0, 4'($urandom_range(0, 3)), 2'b00} | 32'h1000;
            r_ev   = (model_q.size() != 0) ? ($urandom_range(0, 2) != 0) : ($urandom_range(0, 9) == 0);
            if (model_q.size() != 0 && $urandom_range(0, 3) != 0) begin
                r_et   = model_q[0].pt;
                r_etgt = r_et ? model_q[0].tgt : $urandom;
            end else begin
                r_et   = 1'($urandom_range(0, 1));
                r_etgt = {28'h0, 4'($urandom_range(0, 3)), 2'b00} | 32'h1000;
            end
            step(r_fv, r_pc, r_pt, r_ptgt, r_ev, r_et, r_etgt);
        end
        for (int i = 0; i < DEPTH + 2; i++) step(0, 0, 0, 0, 1, 0, 32'h0);
        idle();
        idle();
`ifdef BRU_PERF_CNT_EN
        check("perf_branches", perf_branches, 32'(m_branches));
        check("perf_mispredicts", perf_mispredicts, 32'(m_misp));
`endif

        // Asynchronous reset with three entries outstanding.
        step(1, 32'h700, 0, 32'h0, 0, 0, 0);
        step(1, 32'h710, 1, 32'h720, 0, 0, 0);
        step(1, 32'h730, 0, 32'h0, 1, 0, 32'h0);
        step(1, 32'h740, 0, 32'h0, 0, 0, 0);
        @(posedge clk);
        #2;
        fetch_br_valid = 0;
        ex_br_valid    = 0;
        reset          = 1'b1;
        #1;
        check_reset_outputs();
        model_q.delete();
        model_flush = 0; model_uf = 0; m_branches = 0; m_misp = 0;
        @(negedge clk);
        reset = 1'b0;
        idle();
        step(1, 32'h800, 0, 32'h0, 0, 0, 0);
        step(0, 0, 0, 0, 1, 0, 32'h0);
        idle();
        idle();

        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL missing_updates: got %0d still pending expected 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
